cpu_test_sequencer: RTL
=======================

# cpu_test_sequencer

Sequences a single CPU self-test run inside the user project area and reports its progress on the management IO pads. Holds the CPU in reset, releases it, and watches CPU data-memory writes for a store to the `tohost` address. Drives a 6-bit status code on `mprj_io[37:32]` and the CPU program counter on `mprj_io[31:0]`. Runs a watchdog so that a hung CPU still produces a definite failure code on the pads.

## Interface
Parameters:
- `TOHOST_ADDR`, 32'h0000_1000: byte address whose write ends the test.
- `RESET_CYCLES`, 16: cycles the CPU is held in reset after `start`; minimum 4.
- `TIMEOUT_CYCLES`, 80000: RUN-state watchdog limit; must fit in 24 bits.

Ports:
- `clock`  in  1  single clock for all logic.
- `resetb`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; high requests a test run, low returns to IDLE.
- `cpu_resetb`  out  1  active-low reset to the CPU core.
- `cpu_pc`  in  32  current CPU program counter.
- `mem_we`  in  1  CPU data-memory write strobe, one cycle per store.
- `mem_addr`  in  32  CPU data-memory byte address.
- `mem_wdata`  in  32  CPU store data.
- `io_out`  out  38  pad output values.
- `io_oeb`  out  38  pad output enables, active-low.
- `done`  out  1  high in PASS or FAIL.
- `pass`  out  1  high in PASS only.
- `fail_code`  out  31  `mem_wdata[31:1]` of the failing tohost write; 31'h7FFF_FFFF on timeout.

## Operation
- States are IDLE, START, RUN, PASS and FAIL.
- Status codes on `io_out[37:32]`:
  - IDLE: 6'h00.
  - START and RUN: 6'h18.
  - PASS: 6'h19.
  - FAIL: 6'h1a.
- `io_oeb` is constant:
  - bits 0 and 3 are 1 (input; the pad holds debug-disable and CSB).
  - all other bits are 0.
- `io_out[0]` and `io_out[3]` are always 0.
- IDLE:
  - `cpu_resetb` = 0, `io_out[31:0]` = 0.
  - `start` = 1 moves to START and clears the cycle counter.
- START:
  - `cpu_resetb` = 0; the counter increments each cycle.
  - After exactly `RESET_CYCLES` cycles in START, move to RUN.
  - `mem_we` is ignored in this state.
- RUN:
  - `cpu_resetb` = 1.
  - `io_out[31:0]` = registered `cpu_pc`, masked with bits 0 and 3 forced to 0.
  - The watchdog counts cycles in RUN.
- Tohost write: `mem_we` with `mem_addr == TOHOST_ADDR` in RUN ends the test.
  - The PC register freezes at the `cpu_pc` value of that cycle.
  - `mem_wdata == 1` goes to PASS.
  - Any other value goes to FAIL with `fail_code = mem_wdata[31:1]`.
- Watchdog: the counter reaching `TIMEOUT_CYCLES` in RUN goes to FAIL.
  - `fail_code` = all ones; the PC freezes at the current `cpu_pc`.
- Simultaneous tohost write and timeout in the same cycle: the tohost write wins.
- Writes to other addresses have no effect.
- PASS and FAIL are sticky:
  - `cpu_resetb` returns to 0 (CPU halted); `io_out[31:0]` holds the frozen PC.
  - `start` low returns to IDLE and clears `done`, `pass`, `fail_code` and the PC register.
- `start` falling in START or RUN aborts to IDLE next cycle: `cpu_resetb` = 0, status 6'h00.
- `resetb` low at any time, asynchronously:
  - state IDLE, counter 0, `cpu_resetb` 0, `io_out` 0, `done` 0, `pass` 0, `fail_code` 0.
  - `io_oeb` takes its constant value.

## Timing
- All outputs are registered; every state change is visible on the pads on the clock edge that enters the state.
- `start` rising at edge N: status 6'h18 appears at edge N+1; `cpu_resetb` rises at edge N+1+`RESET_CYCLES`.
- The pad PC lags `cpu_pc` by one cycle in RUN.
- A tohost write sampled at edge M gives status 6'h19/6'h1a, `done` and the frozen PC at edge M+1.
- Timeout: FAIL is entered on the edge where the RUN cycle count equals `TIMEOUT_CYCLES`.
- 6'h18 is guaranteed on the pads for at least `RESET_CYCLES`+1 cycles before any terminal code, so a pad monitor always sees "started" before "done".
- The counter is 24 bits, saturating; it never wraps.

## Test plan
- Pass path: `start`=1 with `RESET_CYCLES`=16; CPU stores 1 to 0x1000 at pc 0x0000_0124.
  - Expect `cpu_resetb` high 17 cycles after `start`.
  - Expect `io_out[37:32]`=0x19, `io_out[31:0]`=0x124, `done`=`pass`=1, `cpu_resetb`=0.
- Fail path: store 0x0000_000B to 0x1000 at pc 0x0000_0210.
  - Expect status 0x1a, `fail_code`=5, pad PC 0x210 (bit 3 masked to 0 → 0x210).
- Timeout: `TIMEOUT_CYCLES`=100, no tohost write.
  - Expect FAIL exactly 100 cycles after RUN entry, `fail_code`=0x7FFF_FFFF.
- Collisions:
  - Tohost write in the same cycle as timeout: expect PASS when wdata=1.
  - Write to 0x1004, or to 0x1000 during START: expect no state change.
- Abort and reset:
  - `start` dropped mid-RUN: expect IDLE and status 0x00 next cycle.
  - `resetb` pulsed low mid-RUN: expect all outputs at reset values immediately, without a clock edge; `io_oeb` = 38'h0000_0009.
- Restart: after PASS, drop `start` then raise it again.
  - Expect a fresh 0x18 sequence, with `done` cleared and the PC zeroed in IDLE.

Source files
------------

// File: rtl/cpu_test_sequencer.sv
// Sequences one CPU self-test run: holds the CPU in reset, releases it, then
// watches for a store to tohost or a watchdog expiry and reports the outcome
// (status code + frozen PC) on the management IO pads.
module cpu_test_sequencer #(
   parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
   parameter int unsigned RESET_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 80000
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic        start,
   output logic        cpu_resetb,
   input  logic [31:0] cpu_pc,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [37:0] io_out,
   output logic [37:0] io_oeb,
   output logic        done,
   output logic        pass,
   output logic [30:0] fail_code
);

   localparam int unsigned CNT_W  = 24;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned STAT_W = 6;
   localparam int unsigned FC_W   = 31;

   localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
   localparam logic [CNT_W-1:0]  RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   // Pads 0 and 3 are inputs (debug-disable, CSB), so their PC bits are forced low.
   localparam logic [PC_W-1:0]   PC_MASK      = 32'hFFFF_FFF6;
   localparam logic [37:0]       OEB_VAL      = 38'h00_0000_0009;

   localparam logic [STAT_W-1:0] ST_IDLE = 6'h00;
   localparam logic [STAT_W-1:0] ST_BUSY = 6'h18;
   localparam logic [STAT_W-1:0] ST_PASS = 6'h19;
   localparam logic [STAT_W-1:0] ST_FAIL = 6'h1a;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_PASS,
      S_FAIL
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [FC_W-1:0]   fc_q, fc_d;
   logic [STAT_W-1:0] status_q, status_d;
   logic              cpu_resetb_q, cpu_resetb_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              tohost_c;
   logic [CNT_W-1:0]  cnt_inc_c;

   // Next-state, counter, PC freeze and registered-output decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_d         = pc_q;
      fc_d         = fc_q;
      status_d     = ST_IDLE;
      cpu_resetb_d = 1'b0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      tohost_c     = mem_we && (mem_addr == TOHOST_ADDR);
      cnt_inc_c    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) state_d = S_START;
         end
         S_START: begin
            cnt_d = cnt_inc_c;
            if (!start) begin
               state_d = S_IDLE;
            end else if (cnt_q == RESET_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_inc_c;
            pc_d  = cpu_pc & PC_MASK;
            if (!start) begin
               state_d = S_IDLE;
            end else if (tohost_c) begin
               // A tohost store outranks a watchdog expiry in the same cycle.
               if (mem_wdata == 32'd1) begin
                  state_d = S_PASS;
               end else begin
                  state_d = S_FAIL;
                  fc_d    = mem_wdata[31:1];
               end
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = S_FAIL;
               fc_d    = '1;
            end
         end
         S_PASS, S_FAIL: begin
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_IDLE) begin
         cnt_d = '0;
         pc_d  = '0;
         fc_d  = '0;
      end

      unique case (state_d)
         S_START: status_d = ST_BUSY;
         S_RUN: begin
            status_d     = ST_BUSY;
            cpu_resetb_d = 1'b1;
         end
         S_PASS: begin
            status_d = ST_PASS;
            done_d   = 1'b1;
            pass_d   = 1'b1;
         end
         S_FAIL: begin
            status_d = ST_FAIL;
            done_d   = 1'b1;
         end
         default: status_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         pc_q         <= '0;
         fc_q         <= '0;
         status_q     <= ST_IDLE;
         cpu_resetb_q <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pc_q         <= pc_d;
         fc_q         <= fc_d;
         status_q     <= status_d;
         cpu_resetb_q <= cpu_resetb_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign io_out     = {status_q, pc_q};
   assign io_oeb     = OEB_VAL;
   assign cpu_resetb = cpu_resetb_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_code  = fc_q;

endmodule
